// File: rtl/elm_pkg.sv
// elm_pkg: shared constants and types for the ELM multiplier datapath.
// Sizes the product/accumulator path and encodes the accumulator FSM.
package elm_pkg;

    localparam int ELM_PW        = 32;
    localparam int ELM_ACC_W     = 40;
    localparam int ELM_MAX_TERMS = 256;
    localparam int ELM_CNT_W     = 9;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } elm_acc_state_t;

    // Saturating add, shape for reuse:
    //   function automatic logic [ACC_W-1:0] sat_add(
    //       input logic [ACC_W-1:0] a, input logic [PW-1:0] b,
    //       output logic carry);
    //   sum = a + zero_ext(b); a carry out of ACC_W bits clamps to all ones.

endpackage

// File: rtl/elm_dot_accumulator_if.sv
// elm_dot_accumulator_if: product stream in, dot-product result out.
// master drives products and consumes results; slave is the accumulator.
interface elm_dot_accumulator_if #(
    parameter int PW    = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 9
);

    logic [PW-1:0]    p_in;
    logic             p_valid;
    logic             p_last;
    logic             p_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_ovf;
    logic             acc_valid;
    logic             acc_ready;

    modport master (
        output p_in, p_valid, p_last, acc_ready,
        input  p_ready, acc_out, acc_cnt, acc_ovf, acc_valid
    );

    modport slave (
        input  p_in, p_valid, p_last, acc_ready,
        output p_ready, acc_out, acc_cnt, acc_ovf, acc_valid
    );

endinterface

// File: rtl/elm_sat_add.sv
// elm_sat_add: unsigned a + zero-extended b, clamped to all ones
// when the sum does not fit in ACC_W bits.
module elm_sat_add #(
    parameter int PW    = 32,
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] a,
    input  logic [PW-1:0]    b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] raw;

    // Widen by one bit so the carry out of ACC_W bits is visible.
    always_comb begin
        raw   = {1'b0, a} + (ACC_W+1)'(b);
        carry = raw[ACC_W];
        sum   = carry ? '1 : raw[ACC_W-1:0];
    end

endmodule

// File: rtl/elm_dot_accumulator.sv
// elm_dot_accumulator: sums a product stream into one saturating
// dot product per vector, closed by p_last or at MAX_TERMS terms.
module elm_dot_accumulator
    import elm_pkg::*;
#(
    parameter int PW        = ELM_PW,
    parameter int ACC_W     = ELM_ACC_W,
    parameter int MAX_TERMS = ELM_MAX_TERMS,
    parameter int CNT_W     = ELM_CNT_W
) (
    input logic                 clk,
    input logic                 rst_n,
    elm_dot_accumulator_if.slave bus
);

    elm_acc_state_t   state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W-1:0] acc_out_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic             acc_ovf_q;
    logic             acc_valid_q;
    logic             bubble;

    logic             p_ready;
    logic             beat;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             close;

    // Ready is held off while a result is pending and for one bubble after.
    assign p_ready = rst_n && !acc_valid_q && !bubble;
    assign beat    = bus.p_valid && p_ready;

    // First term of a vector starts from zero rather than the stale acc.
    always_comb begin
        add_a   = (state == ACCUM) ? acc : '0;
        cnt_nxt = (state == ACCUM) ? cnt + CNT_W'(1) : CNT_W'(1);
        ovf_nxt = ((state == ACCUM) && ovf) || carry;
        close   = bus.p_last || (cnt_nxt == CNT_W'(MAX_TERMS));
    end

    elm_sat_add #(
        .PW    (PW),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a     (add_a),
        .b     (bus.p_in),
        .sum   (sum),
        .carry (carry)
    );

    // Vector FSM: accumulate beats, publish on close, release on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            acc_out_q   <= '0;
            acc_cnt_q   <= '0;
            acc_ovf_q   <= 1'b0;
            acc_valid_q <= 1'b0;
            bubble      <= 1'b0;
        end else begin
            bubble <= 1'b0;
            unique case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc <= sum;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (close) begin
                            acc_out_q   <= sum;
                            acc_cnt_q   <= cnt_nxt;
                            acc_ovf_q   <= ovf_nxt;
                            acc_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        acc_valid_q <= 1'b0;
                        acc         <= '0;
                        cnt         <= '0;
                        ovf         <= 1'b0;
                        bubble      <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p_ready   = p_ready;
    assign bus.acc_out   = acc_out_q;
    assign bus.acc_cnt   = acc_cnt_q;
    assign bus.acc_ovf   = acc_ovf_q;
    assign bus.acc_valid = acc_valid_q;

endmodule
